sync_filter: RTL and testbench
==============================

SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 SHALL have parameter STAGES, default 2: synchronizer flops per channel, legal range >=2.
REQ-002 SHALL have parameter WIDTH, default 4: number of independent single-bit channels, legal range >=1.
REQ-003 SHALL have parameter FILTER_CYCLES, default 3: consecutive enabled cycles a new value must persist before acceptance, legal range >=1.
REQ-004 SHALL have parameter RESET_VALUE [WIDTH-1:0], default all-zero: filtered value loaded on reset.
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-007 SHALL have port ena  input  1  advance enable; 0 freezes all state.
REQ-008 SHALL have port data_in  input  WIDTH  asynchronous channel inputs.
REQ-009 SHALL have port data_out  output  WIDTH  synchronized, glitch-filtered value, registered.
REQ-010 SHALL have port rise  output  WIDTH  one-cycle pulse per channel on accepted 0->1, registered.
REQ-011 SHALL have port fall  output  WIDTH  one-cycle pulse per channel on accepted 1->0, registered.
REQ-012 SHALL have port any_change  output  1  registered OR of rise|fall, same cycle as the pulses.

Function
REQ-013 Each channel SHALL pass through a chain of STAGES flops; the chain shifts only on edges where ena=1; sync[i] is the last stage.
REQ-014 Each channel SHALL hold a filtered bit filt[i] (drives data_out[i]) and a counter cnt[i] of width clog2(FILTER_CYCLES+1).
REQ-015 On an enabled edge with sync[i]==filt[i], cnt[i] SHALL clear to 0 and filt[i] SHALL hold.
REQ-016 On an enabled edge with sync[i]!=filt[i] and cnt[i]<FILTER_CYCLES-1, cnt[i] SHALL increment and filt[i] SHALL hold.
REQ-017 On an enabled edge with sync[i]!=filt[i] and cnt[i]==FILTER_CYCLES-1, filt[i] SHALL load sync[i] and cnt[i] SHALL clear to 0 (accept event).
REQ-018 FILTER_CYCLES=1 SHALL degenerate to accepting any mismatch on the first enabled edge (one extra register stage, no filtering).
REQ-019 A mismatch lasting fewer than FILTER_CYCLES consecutive enabled edges SHALL leave filt unchanged and SHALL generate no pulse (glitch rejection); counter restarts from 0 on the next mismatch.
REQ-020 On an accept event, rise[i] (new value 1) or fall[i] (new value 0) SHALL be 1 on the edge where data_out[i] updates, for exactly one cycle.
REQ-021 rise, fall, any_change SHALL be 0 on every edge without an accept event, including every edge with ena=0.
REQ-022 Latency: a data_in step stable from before edge 1 with ena=1 throughout SHALL appear on data_out at edge STAGES+FILTER_CYCLES.
REQ-023 Channels SHALL be fully independent; simultaneous accept events on multiple channels SHALL produce all corresponding pulses in the same cycle.
REQ-024 ena=0 mid-filter SHALL freeze cnt and chain; counting SHALL resume from the frozen value when ena returns to 1.
REQ-025 No combinational path SHALL exist from data_in or ena to any output.

Reset
REQ-026 While rst=1, all chain flops SHALL be 0 except the last stage, which SHALL equal RESET_VALUE; filt=RESET_VALUE, cnt=0, rise=fall=0, any_change=0, independent of clk.
REQ-027 Reset asserted mid-filter SHALL discard partial counts; after release, acceptance SHALL require a fresh full STAGES+FILTER_CYCLES sequence.
REQ-028 Release of rst with data_in==RESET_VALUE SHALL produce no pulse; with data_in!=RESET_VALUE, the difference SHALL be accepted normally with pulses.

Verification (STAGES=2, WIDTH=4, FILTER_CYCLES=3, RESET_VALUE=4'h0)
REQ-029 rst=1, data_in=4'hF, clocks running -> data_out=4'h0, rise=fall=4'h0, any_change=0 throughout reset.
REQ-030 After reset, ena=1, data_in 4'h0->4'h1 before edge 1 and held -> data_out=4'h1 first at edge 5, rise=4'h1 only at edge 5, any_change=1 only at edge 5.
REQ-031 Bit1 pulsed high for 2 cycles -> data_out[1] stays 0, no pulses; pulsed high for 3 cycles -> data_out[1] high for 3 cycles, one rise[1] pulse then one fall[1] pulse 3 cycles later.
REQ-032 data_out=4'h4, data_in 4'h4->4'h9 at once -> single edge with rise=4'h9, fall=4'h4, any_change=1, data_out=4'h9.
REQ-033 Step on bit3, ena dropped for 4 cycles after cnt[3] reaches 1 -> outputs frozen, no pulses during ena=0; acceptance occurs 2 enabled edges after ena returns (one more increment, then accept).
REQ-034 Step on bit2, rst pulsed once cnt[2] is nonzero -> data_out[2]=0; after release, acceptance occurs at edge 5 after release, not earlier.

Source files
------------

// File: rtl/sync_filter.sv
// Multi-channel input synchronizer with persistence-based glitch filter.
// Each channel must hold a new value for FILTER_CYCLES enabled edges before it is accepted.
module sync_filter #(
    parameter int              STAGES        = 2,
    parameter int              WIDTH         = 4,
    parameter int              FILTER_CYCLES = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

    // chain[STAGES-1] is the synchronized sample; it resets to RESET_VALUE so release is quiet
    logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             sync;
    logic [WIDTH-1:0]             filt;
    logic [WIDTH-1:0][CW-1:0]     cnt;
    logic [WIDTH-1:0][CW-1:0]     cnt_next;
    logic [WIDTH-1:0]             accept;

    assign sync     = chain[STAGES-1];
    assign data_out = filt;

    always_comb begin
        accept   = '0;
        cnt_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] != filt[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // accept implies sync differs from filt, so toggling those bits loads the new value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain      <= {RESET_VALUE, {((STAGES-1)*WIDTH){1'b0}}};
            filt       <= RESET_VALUE;
            cnt        <= '0;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else if (ena) begin
            chain      <= {chain[STAGES-2:0], data_in};
            filt       <= filt ^ accept;
            cnt        <= cnt_next;
            rise       <= accept & sync;
            fall       <= accept & ~sync;
            any_change <= |accept;
        end else begin
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_filter.sv
// Directed bench for sync_filter with STAGES=2, WIDTH=4, FILTER_CYCLES=3, RESET_VALUE=0.
// Outputs are sampled 1 time unit after each rising edge; expected values are hand-derived.
module tb_sync_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_change;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_filter #(
        .STAGES(2),
        .WIDTH(4),
        .FILTER_CYCLES(3),
        .RESET_VALUE(4'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .data_in(data_in),
        .data_out(data_out),
        .rise(rise),
        .fall(fall),
        .any_change(any_change)
    );

    task automatic applyStimulus(input logic [3:0] d, input logic e);
        data_in = d;
        ena     = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] e_out, input logic [3:0] e_rise,
                               input logic [3:0] e_fall, input logic e_any);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {data_out, rise, fall, any_change};
        exp = {e_out, e_rise, e_fall, e_any};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed out=%h rise=%h fall=%h any=%b, expected out=%h rise=%h fall=%h any=%b",
                   tag, data_out, rise, fall, any_change, e_out, e_rise, e_fall, e_any);
        end
    endtask

    // n edges with a stable data_out and no pulses
    task automatic quietEdges(input string tag, input int n, input logic [3:0] e_out);
        for (int k = 0; k < n; k++) begin
            tick();
            checkOutput(tag, e_out, 4'h0, 4'h0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'hF, 1'b1);

        // asynchronous reset value before any clock edge, then held across running clocks
        #2;
        checkOutput("reset_async", 4'h0, 4'h0, 4'h0, 1'b0);
        quietEdges("reset_hold", 3, 4'h0);

        // release with data_in equal to RESET_VALUE: nothing happens
        applyStimulus(4'h0, 1'b1);
        rst = 1'b0;
        quietEdges("release_quiet", 4, 4'h0);

        // basic latency: step on bit0 accepted at edge STAGES+FILTER_CYCLES = 5
        applyStimulus(4'h1, 1'b1);
        quietEdges("latency_wait", 4, 4'h0);
        tick();
        checkOutput("latency_accept", 4'h1, 4'h1, 4'h0, 1'b1);
        tick();
        checkOutput("latency_after", 4'h1, 4'h0, 4'h0, 1'b0);

        // 2-cycle glitch on bit1 is rejected
        applyStimulus(4'h3, 1'b1);
        tick();
        checkOutput("glitch2_e1", 4'h1, 4'h0, 4'h0, 1'b0);
        tick();
        checkOutput("glitch2_e2", 4'h1, 4'h0, 4'h0, 1'b0);
        applyStimulus(4'h1, 1'b1);
        quietEdges("glitch2_rest", 4, 4'h1);

        // 3-cycle pulse on bit1 passes: rise at edge 5, fall at edge 8
        applyStimulus(4'h3, 1'b1);
        tick();
        checkOutput("pulse3_e1", 4'h1, 4'h0, 4'h0, 1'b0);
        tick();
        checkOutput("pulse3_e2", 4'h1, 4'h0, 4'h0, 1'b0);
        tick();
        checkOutput("pulse3_e3", 4'h1, 4'h0, 4'h0, 1'b0);
        applyStimulus(4'h1, 1'b1);
        tick();
        checkOutput("pulse3_e4", 4'h1, 4'h0, 4'h0, 1'b0);
        tick();
        checkOutput("pulse3_rise", 4'h3, 4'h2, 4'h0, 1'b1);
        quietEdges("pulse3_high", 2, 4'h3);
        tick();
        checkOutput("pulse3_fall", 4'h1, 4'h0, 4'h2, 1'b1);
        quietEdges("pulse3_after", 1, 4'h1);

        // 1 -> 4: simultaneous fall on bit0 and rise on bit2
        applyStimulus(4'h4, 1'b1);
        quietEdges("to4_wait", 4, 4'h1);
        tick();
        checkOutput("to4_accept", 4'h4, 4'h4, 4'h1, 1'b1);
        quietEdges("to4_after", 1, 4'h4);

        // 4 -> 9: three channels change on one edge
        applyStimulus(4'h9, 1'b1);
        quietEdges("to9_wait", 4, 4'h4);
        tick();
        checkOutput("to9_accept", 4'h9, 4'h9, 4'h4, 1'b1);
        quietEdges("to9_after", 1, 4'h9);

        // bit3 falls; ena dropped for 4 edges once cnt[3] is 1
        applyStimulus(4'h1, 1'b1);
        quietEdges("ena_count", 3, 4'h9);
        applyStimulus(4'h1, 1'b0);
        quietEdges("ena_frozen", 4, 4'h9);
        applyStimulus(4'h1, 1'b1);
        tick();
        checkOutput("ena_resume1", 4'h9, 4'h0, 4'h0, 1'b0);
        tick();
        checkOutput("ena_accept", 4'h1, 4'h0, 4'h8, 1'b1);
        quietEdges("ena_after", 1, 4'h1);

        // bit2 rises; reset once cnt[2] is nonzero discards progress and filt
        applyStimulus(4'h5, 1'b1);
        quietEdges("rst_mid_count", 4, 4'h1);
        rst = 1'b1;
        #2;
        checkOutput("rst_mid_async", 4'h0, 4'h0, 4'h0, 1'b0);
        tick();
        checkOutput("rst_mid_hold", 4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        quietEdges("rst_fresh_wait", 4, 4'h0);
        tick();
        checkOutput("rst_fresh_accept", 4'h5, 4'h5, 4'h0, 1'b1);
        quietEdges("rst_fresh_after", 1, 4'h5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
